// File: rtl/nv_io_axil_regs_if.sv
// AXI4-Lite bus bundle for the nv_io_axil_regs register block.
// The slave modport is used by the register block; the master modport by whoever drives it.
interface nv_io_axil_regs_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/nv_io_axil_regs.sv
// AXI4-Lite register block driving general-purpose IO pins.
// REG0 -> io_out, REG1 -> io_oe, REG2/REG3 scratch, STAT = synchronised io_in.
// Write and read channels run independent three-state handshakes; all outputs are flops.
module nv_io_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    nv_io_axil_regs_if.slave              s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] io_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0] io_oe,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] io_in
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int NUM_LANES = DW / 8;
    localparam logic [DW-1:0] ZERO_WORD = {DW{1'b0}};

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_ACCEPT = 2'b01,
        W_RESP   = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'b00,
        R_ACCEPT = 2'b01,
        R_RESP   = 2'b10
    } rd_state_t;

    wr_state_t wr_state_r;
    wr_state_t wr_next_s;
    rd_state_t rd_state_r;
    rd_state_t rd_next_s;

    logic          awready_r;
    logic          bvalid_r;
    logic          arready_r;
    logic          rvalid_r;
    logic [DW-1:0] rdata_r;

    logic [DW-1:0] reg0_r;
    logic [DW-1:0] reg1_r;
    logic [DW-1:0] reg2_r;
    logic [DW-1:0] reg3_r;
    logic [DW-1:0] sync_r;
    logic [DW-1:0] stat_r;
    logic [DW-1:0] rd_mux_s;

    logic [AW-3:0] wr_idx_s;
    logic [AW-3:0] rd_idx_s;
    logic          unused_s;

    // Byte-lane merge: lanes with a strobe take the new byte, the others keep the old one.
    function automatic logic [DW-1:0] apply_strb(
        input logic [DW-1:0]        old_v,
        input logic [DW-1:0]        new_v,
        input logic [NUM_LANES-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_v;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Byte offset within a word and protection bits carry no meaning here.
    assign unused_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign wr_idx_s = s_axi.awaddr[AW-1:2];
    assign rd_idx_s = s_axi.araddr[AW-1:2];

    // Write channel next state: accept only when address and data are both offered.
    always_comb begin
        wr_next_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (s_axi.awvalid && s_axi.wvalid) begin
                    wr_next_s = W_ACCEPT;
                end else begin
                    wr_next_s = W_IDLE;
                end
            end
            W_ACCEPT: wr_next_s = W_RESP;
            W_RESP: begin
                if (s_axi.bready) begin
                    wr_next_s = W_IDLE;
                end else begin
                    wr_next_s = W_RESP;
                end
            end
            default: wr_next_s = W_IDLE;
        endcase
    end

    // Write channel state and registered handshake outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state_r <= W_IDLE;
            awready_r  <= 1'b0;
            bvalid_r   <= 1'b0;
        end else begin
            wr_state_r <= wr_next_s;
            awready_r  <= (wr_next_s == W_ACCEPT);
            bvalid_r   <= (wr_next_s == W_RESP);
        end
    end

    // Read channel next state: one outstanding read at a time.
    always_comb begin
        rd_next_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    rd_next_s = R_ACCEPT;
                end else begin
                    rd_next_s = R_IDLE;
                end
            end
            R_ACCEPT: rd_next_s = R_RESP;
            R_RESP: begin
                if (s_axi.rready) begin
                    rd_next_s = R_IDLE;
                end else begin
                    rd_next_s = R_RESP;
                end
            end
            default: rd_next_s = R_IDLE;
        endcase
    end

    // Read channel state and registered handshake outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
        end else begin
            rd_state_r <= rd_next_s;
            arready_r  <= (rd_next_s == R_ACCEPT);
            rvalid_r   <= (rd_next_s == R_RESP);
        end
    end

    // Register file update on the edge that closes the write-accept cycle.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            reg0_r <= ZERO_WORD;
            reg1_r <= ZERO_WORD;
            reg2_r <= ZERO_WORD;
            reg3_r <= ZERO_WORD;
        end else if (wr_state_r == W_ACCEPT) begin
            case (wr_idx_s)
                3'd0:    reg0_r <= apply_strb(reg0_r, s_axi.wdata, s_axi.wstrb);
                3'd1:    reg1_r <= apply_strb(reg1_r, s_axi.wdata, s_axi.wstrb);
                3'd2:    reg2_r <= apply_strb(reg2_r, s_axi.wdata, s_axi.wstrb);
                3'd3:    reg3_r <= apply_strb(reg3_r, s_axi.wdata, s_axi.wstrb);
                default: begin
                    // STAT and reserved slots are not writable.
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous input pins.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            sync_r <= ZERO_WORD;
            stat_r <= ZERO_WORD;
        end else begin
            sync_r <= io_in;
            stat_r <= sync_r;
        end
    end

    // Read mux; reserved slots return zero.
    always_comb begin
        rd_mux_s = ZERO_WORD;
        case (rd_idx_s)
            3'd0:    rd_mux_s = reg0_r;
            3'd1:    rd_mux_s = reg1_r;
            3'd2:    rd_mux_s = reg2_r;
            3'd3:    rd_mux_s = reg3_r;
            3'd4:    rd_mux_s = stat_r;
            default: rd_mux_s = ZERO_WORD;
        endcase
    end

    // Capture read data at the end of the accept cycle, so a same-edge write is not yet visible.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rdata_r <= ZERO_WORD;
        end else if (rd_state_r == R_ACCEPT) begin
            rdata_r <= rd_mux_s;
        end
    end

    assign s_axi.awready = awready_r;
    assign s_axi.wready  = awready_r;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = 2'b00;

    assign io_out = reg0_r;
    assign io_oe  = reg1_r;

endmodule

// File: tb/tb_nv_io_axil_regs.sv
// Self-checking bench for nv_io_axil_regs: directed vector table, hand-written
// handshake corner sequences, and random traffic against a word-level model.
module tb_nv_io_axil_regs;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] io_out;
    logic [31:0] io_oe;
    logic [31:0] io_in;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [0:3];

    nv_io_axil_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    nv_io_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .ACLK    (clk),
        .ARESETN (aresetn),
        .s_axi   (bus),
        .io_out  (io_out),
        .io_oe   (io_oe),
        .io_in   (io_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx < 4) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mreg[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (idx < 4) return mreg[idx];
        if (idx == 4) return io_in;
        return 32'h0;
    endfunction

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay);
        int n;
        @(negedge clk);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awprot  = 3'($urandom);
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.awready !== 1'b1 && n < 20);
        check("aw_accept_latency", n, 1);
        check("wready_with_awready", 32'(bus.wready), 1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            check("bvalid_held", 32'(bus.bvalid), 1);
            @(negedge clk);
        end
        check("bvalid", 32'(bus.bvalid), 1);
        check("bresp", 32'(bus.bresp), 0);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bvalid_drop", 32'(bus.bvalid), 0);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int rdelay, output logic [31:0] data);
        int n;
        @(negedge clk);
        bus.araddr  = addr;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.arready !== 1'b1 && n < 20);
        check("ar_accept_latency", n, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        data = bus.rdata;
        for (int i = 0; i < rdelay; i++) begin
            check("rvalid_held", 32'(bus.rvalid), 1);
            check("rdata_stable", bus.rdata, data);
            @(negedge clk);
        end
        check("rvalid", 32'(bus.rvalid), 1);
        check("rresp", 32'(bus.rresp), 0);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("rvalid_drop", 32'(bus.rvalid), 0);
    endtask

    vec_t vecs [16];

    initial begin
        logic [31:0] rd;
        int          r;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        vecs[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 5'h04, 32'h0000_0002, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 5'h08, 32'h0000_0003, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0001};
        vecs[5]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0002};
        vecs[6]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0003};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0000_0004};
        vecs[8]  = '{1'b1, 5'h08, 32'hAABB_CCDD, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 5'h08, 32'h1122_3344, 4'h5, 32'h0};
        vecs[10] = '{1'b0, 5'h08, 32'h0,         4'h0, 32'hAA22_CC44};
        vecs[11] = '{1'b1, 5'h0E, 32'h1234_5678, 4'hC, 32'h0};
        vecs[12] = '{1'b0, 5'h0F, 32'h0,         4'h0, 32'h1234_0004};
        vecs[13] = '{1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[14] = '{1'b0, 5'h14, 32'h0,         4'h0, 32'h0};
        vecs[15] = '{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0};

        for (int i = 0; i < 4; i++) mreg[i] = 32'h0;
        aresetn     = 1'b0;
        io_in       = 32'h0;
        bus.awaddr  = 5'h0;  bus.awprot = 3'h0; bus.awvalid = 1'b0;
        bus.wdata   = 32'h0; bus.wstrb  = 4'h0; bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = 5'h0;  bus.arprot = 3'h0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_wready",  32'(bus.wready), 0);
        check("rst_bvalid",  32'(bus.bvalid), 0);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_rvalid",  32'(bus.rvalid), 0);
        check("rst_rdata",   bus.rdata, 0);
        check("rst_io_out",  io_out, 0);
        check("rst_io_oe",   io_oe, 0);
        aresetn = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, i % 2, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
        end
        check("io_out_reg0", io_out, 32'h0000_0001);
        check("io_oe_reg1",  io_oe,  32'h0000_0002);

        // AWVALID long before WVALID; BREADY held off while a second write waits
        @(negedge clk);
        bus.awaddr = 5'h08; bus.wdata = 32'h5A5A_5A5A; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aw_only_no_accept", 32'(bus.awready), 0);
        end
        bus.wvalid = 1'b1;
        @(negedge clk);
        check("late_w_awready", 32'(bus.awready), 1);
        check("late_w_wready",  32'(bus.wready), 1);
        @(negedge clk);
        check("late_w_bvalid", 32'(bus.bvalid), 1);
        check("late_w_awready_off", 32'(bus.awready), 0);
        bus.awaddr = 5'h0C; bus.wdata = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bhold_bvalid", 32'(bus.bvalid), 1);
            check("bhold_no_accept", 32'(bus.awready), 0);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bhold_bvalid_drop", 32'(bus.bvalid), 0);
        check("bhold_no_accept2", 32'(bus.awready), 0);
        @(negedge clk);
        check("second_accept", 32'(bus.awready), 1);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("second_bvalid", 32'(bus.bvalid), 1);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        model_write(5'h08, 32'h5A5A_5A5A, 4'hF);
        model_write(5'h0C, 32'h0000_0077, 4'hF);
        axi_read(5'h08, 0, rd); check("late_w_reg2", rd, model_read(5'h08));
        axi_read(5'h0C, 0, rd); check("late_w_reg3", rd, model_read(5'h0C));

        // STAT path: two-flop lag, read-only, reserved reads zero
        io_in = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        axi_read(5'h10, 0, rd); check("stat_read", rd, 32'hDEAD_BEEF);
        axi_write(5'h10, 32'h0, 4'hF, 0);
        axi_read(5'h10, 0, rd); check("stat_ro", rd, 32'hDEAD_BEEF);
        axi_read(5'h18, 0, rd); check("reserved_0x18", rd, 32'h0);
        @(negedge clk);
        io_in = 32'h0BAD_F00D;
        bus.araddr = 5'h10; bus.arvalid = 1'b1;
        @(negedge clk);
        check("stat_lag_arready", 32'(bus.arready), 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("stat_lag_old_value", bus.rdata, 32'hDEAD_BEEF);
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        axi_read(5'h10, 0, rd); check("stat_new_value", rd, 32'h0BAD_F00D);

        // Same-cycle read and write of REG0 returns the pre-write value
        @(negedge clk);
        bus.araddr = 5'h00; bus.arvalid = 1'b1;
        bus.awaddr = 5'h00; bus.wdata = 32'h0000_0055; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        check("coinc_arready", 32'(bus.arready), 1);
        check("coinc_awready", 32'(bus.awready), 1);
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("coinc_rvalid", 32'(bus.rvalid), 1);
        check("coinc_bvalid", 32'(bus.bvalid), 1);
        check("coinc_pre_write", bus.rdata, 32'h0000_0001);
        check("coinc_io_out", io_out, 32'h0000_0055);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0; bus.bready = 1'b0;
        model_write(5'h00, 32'h0000_0055, 4'hF);
        axi_read(5'h00, 0, rd); check("coinc_post_write", rd, 32'h0000_0055);

        // Random traffic against the model
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                a = 5'($urandom_range(0, 31));
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3));
                model_write(a, d, s);
            end else if (r < 9) begin
                a = 5'($urandom_range(0, 31));
                axi_read(a, $urandom_range(0, 3), rd);
                check($sformatf("rand_read_%02h", a), rd, model_read(a));
            end else begin
                io_in = $urandom;
                repeat (3) @(negedge clk);
            end
        end
        check("rand_io_out", io_out, mreg[0]);
        check("rand_io_oe",  io_oe,  mreg[1]);

        // Reset while both responses are pending
        @(negedge clk);
        bus.araddr = 5'h00; bus.arvalid = 1'b1;
        bus.awaddr = 5'h04; bus.wdata = 32'h0000_0099; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        check("pre_rst_arready", 32'(bus.arready), 1);
        check("pre_rst_awready", 32'(bus.awready), 1);
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("pre_rst_bvalid", 32'(bus.bvalid), 1);
        check("pre_rst_rvalid", 32'(bus.rvalid), 1);
        aresetn = 1'b0;
        @(negedge clk);
        check("mid_rst_bvalid", 32'(bus.bvalid), 0);
        check("mid_rst_rvalid", 32'(bus.rvalid), 0);
        check("mid_rst_rdata",  bus.rdata, 0);
        check("mid_rst_io_out", io_out, 0);
        check("mid_rst_io_oe",  io_oe, 0);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) mreg[i] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_b", 32'(bus.bvalid), 0);
            check("post_rst_no_r", 32'(bus.rvalid), 0);
        end
        for (int i = 0; i < 8; i++) begin
            a = 5'(i * 4);
            axi_read(a, 0, rd);
            check($sformatf("post_rst_read_%02h", a), rd, model_read(a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
